int_to_fp: RTL and testbench

- Multi-cycle converter from a signed two's-complement integer to an IEEE 754 single-precision float.
- It is the packing counterpart of fpadd. fpadd unpacks floats into sign/exponent/mantissa; this block builds them from integer data so that integer results can feed fpadd.
- Uses the same start/done handshake as fpadd.
- Normalizes iteratively, one left shift per cycle, then rounds to nearest, ties to even.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_round_rne.sv | 25 ++
 rtl/int_to_fp.sv | 114 +++++++++++
 tb/tb_int_to_fp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP datapath blocks.
// Holds field widths, the bias, the start/done FSM state type and pack/unpack helpers.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp_t;

    function automatic logic [31:0] fp_pack(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exp,
        input logic [FP_MANT_W-1:0] mant
    );
        fp_t f;
        f.sign = sign;
        f.exp  = exp;
        f.mant = mant;
        return f;
    endfunction

    function automatic fp_t fp_unpack(input logic [31:0] bits);
        return fp_t'(bits);
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest, ties-to-even on a 23-bit mantissa with guard/sticky bits.
// Ports: mant/guard/sticky/exp in; mant_rnd (rounded mantissa) and exp_rnd (carry-adjusted exponent) out.
import fp_pkg::*;

module fp_round_rne (
    input  logic [FP_MANT_W-1:0] mant,
    input  logic                 guard,
    input  logic                 sticky,
    input  logic [FP_EXP_W:0]    exp,
    output logic [FP_MANT_W-1:0] mant_rnd,
    output logic [FP_EXP_W:0]    exp_rnd
);

    logic               up;
    logic [FP_MANT_W:0] sum;

    // Exact halfway cases round toward the even mantissa.
    assign up  = guard & (sticky | mant[0]);
    assign sum = {1'b0, mant} + {{FP_MANT_W{1'b0}}, up};

    // On carry-out the low bits are already zero: 1.111..1 + ulp = 10.000..0.
    assign mant_rnd = sum[FP_MANT_W-1:0];
    assign exp_rnd  = exp + {{FP_EXP_W{1'b0}}, sum[FP_MANT_W]};

endmodule

// File: rtl/int_to_fp.sv
// Multi-cycle signed integer to IEEE-754 single converter, one normalising shift per cycle.
// Ports: clk, reset (async, active-high), start, a (signed INT_W); result (float) valid while done.
import fp_pkg::*;

module int_to_fp #(
    parameter int INT_W    = 32,
    parameter int EXP_BIAS = FP_BIAS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [INT_W-1:0] a,
    output logic [31:0]      result,
    output logic             done
);

    localparam logic [INT_W-1:0] ONE      = {{(INT_W-1){1'b0}}, 1'b1};
    localparam logic [8:0]       EXP_INIT = 9'(EXP_BIAS + INT_W - 1);

    fp_state_t        state_q, state_d;
    logic             sign_q, sign_d;
    logic [INT_W-1:0] mag_q, mag_d;
    logic [8:0]       exp_q, exp_d;
    logic [31:0]      result_q, result_d;
    logic             done_q, done_d;

    logic [INT_W-1:0]     a_mag;
    logic [30:0]          frac;
    logic [FP_MANT_W-1:0] mant_rnd;
    logic [8:0]           exp_rnd;
    logic [7:0]           exp_field;

    // Two's complement negation; the most negative value maps to 2^(INT_W-1) unsigned.
    assign a_mag = a[INT_W-1] ? (~a + ONE) : a;

    // Bits below the leading one, left-aligned to 31 bits so the mantissa,
    // guard and sticky slices are the same for every INT_W.
    assign frac = 31'(mag_q[INT_W-2:0]) << (32 - INT_W);

    fp_round_rne u_round (
        .mant     (frac[30:8]),
        .guard    (frac[7]),
        .sticky   (|frac[6:0]),
        .exp      (exp_q),
        .mant_rnd (mant_rnd),
        .exp_rnd  (exp_rnd)
    );

    // Unreachable for INT_W<=32; keeps an out-of-range exponent from wrapping.
    assign exp_field = (exp_rnd >= {1'b0, FP_EXP_MAX}) ? FP_EXP_MAX
                                                       : exp_rnd[7:0];

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sign_d = a[INT_W-1];
                    mag_d  = a_mag;
                    exp_d  = EXP_INIT;
                    done_d = 1'b0;
                    if (a == '0) begin
                        result_d = 32'h0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[INT_W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 9'd1;
                end
            end
            ROUND: begin
                result_d = fp_pack(sign_q, exp_field, mant_rnd);
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= 9'd0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp (INT_W=32) against an arithmetic reference model.
// Latency is counted in clock edges after the edge that accepts start.
module tb_int_to_fp;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] result;
    logic        done;

    int errors = 0;
    int checks = 0;

    int_to_fp #(.INT_W(32), .EXP_BIAS(127)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Position of the most significant set bit of |v|; -1 for zero.
    function automatic int msb_pos(input logic [31:0] v);
        int     sv;
        longint m;
        int     p;
        sv = v;
        m  = sv;
        if (m < 0) m = -m;
        if (m == 0) return -1;
        p = 40;
        while (((m >> p) & 64'sd1) == 0) p--;
        return p;
    endfunction

    // Float value of a signed 32-bit integer, rounded to nearest even.
    function automatic logic [31:0] ref_fp(input logic [31:0] v);
        int     sv;
        longint m, q, r, half;
        int     p, e, sh;
        logic   sg;
        sv = v;
        m  = sv;
        sg = (m < 0);
        if (sg) m = -m;
        if (m == 0) return 32'h0;
        p = msb_pos(v);
        e = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (r > half || (r == half && (q & 64'sd1) == 1)) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {sg, 8'(e), 23'(q & 64'h7FFFFF)};
    endfunction

    function automatic int ref_lat(input logic [31:0] v);
        int p;
        p = msb_pos(v);
        if (p < 0) return 0;
        return (31 - p) + 2;
    endfunction

    // Drive one start and wait for done; lat counts edges after the start edge.
    task automatic run_conv(input logic [31:0] v, output logic [31:0] res,
                            output int lat, output bit tmo);
        @(negedge clk);
        start = 1'b1;
        a     = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        tmo   = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) tmo = 1'b1;
        res = result;
    endtask

    task automatic check_conv(input string name, input logic [31:0] v);
        logic [31:0] res;
        int          lat;
        bit          tmo;
        run_conv(v, res, lat, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL %s a=%h: done timeout", name, v);
        end else if (res !== ref_fp(v)) begin
            errors++;
            $display("FAIL %s a=%h: result=%h expected=%h", name, v, res, ref_fp(v));
        end
        checks++;
        if (lat != ref_lat(v)) begin
            errors++;
            $display("FAIL %s_lat a=%h: latency=%0d expected=%0d", name, v, lat, ref_lat(v));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: done=%b result=%h expected done=0 result=0", done, result);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: done=%b result=%h expected 0/0", done, result);
        end
    endtask

    task automatic test_directed;
        logic [31:0] vec [10];
        vec = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h01000001,
                32'h01000003, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd16777215};
        // Spot-check the model itself against hand-derived encodings.
        checks++;
        if (ref_fp(32'h7FFFFFFF) !== 32'h4F000000 || ref_fp(32'h01000003) !== 32'h4B800002 ||
            ref_fp(32'h80000000) !== 32'hCF000000 || ref_fp(32'd100) !== 32'h42C80000) begin
            errors++;
            $display("FAIL model_selfcheck: reference encodings disagree");
        end
        foreach (vec[i]) check_conv("directed", vec[i]);
    endtask

    task automatic test_hold;
        logic [31:0] res;
        int          lat;
        bit          tmo;
        run_conv(32'h12345678, res, lat, tmo);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || result !== ref_fp(32'h12345678)) begin
            errors++;
            $display("FAIL hold: done=%b result=%h expected done=1 result=%h",
                     done, result, ref_fp(32'h12345678));
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            check_conv("back_to_back", v);
        end
    endtask

    task automatic test_random;
        logic [31:0] v;
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            check_conv("random", v);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start = 1'b1;
        a     = 32'd5;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (result !== 32'h3F800000 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: result=%h done=%b expected 3f800000/1", result, done);
        end
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL start_ignored_lat: latency=%0d expected=33", lat);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: done=%b result=%h expected 0/0", done, result);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_nodone: done=%b expected 0", done);
        end
        @(negedge clk);
        reset = 1'b0;
        check_conv("after_abort", 32'hFFFFFF9C);
        checks++;
        if (result !== 32'hC2C80000) begin
            errors++;
            $display("FAIL after_abort_const: result=%h expected c2c80000", result);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_hold;
        test_back_to_back;
        test_random;
        test_start_ignored;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
